// File: rtl/fifo_lifo_pkg.sv
// Shared constants and width helpers for the fifo/lifo buffer.
// Optional peek output is enabled with the FIFOLIFO_PEEK_EN macro.
package fifo_lifo_pkg;

    localparam logic MODE_FIFO = 1'b0;
    localparam logic MODE_LIFO = 1'b1;

    // Bits needed to encode the values 0 .. n-1, never less than one.
    function automatic int bits_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_lifo_buffer_if.sv
// Producer/consumer side signal bundle of the fifo/lifo buffer.
// Optional feature macro: FIFOLIFO_PEEK_EN adds peek_data.
interface fifo_lifo_buffer_if
    import fifo_lifo_pkg::*;
#(
    parameter int DAT_WIDTH = 32,
    parameter int DEPTH     = 64
);
    localparam int CNT_W = bits_for(DEPTH + 1);

    logic                 mode_sel;
    logic                 Wren;
    logic                 Rden;
    logic [DAT_WIDTH-1:0] data_in;
    logic                 err_clr;
    logic [DAT_WIDTH-1:0] DataOut;
    logic                 data_valid;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [CNT_W-1:0]     count;
    logic                 overflow;
    logic                 underflow;
    logic                 mode_q;
`ifdef FIFOLIFO_PEEK_EN
    logic [DAT_WIDTH-1:0] peek_data;
`endif

    modport master (
        output mode_sel, Wren, Rden, data_in, err_clr,
        input  DataOut, data_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow, mode_q
`ifdef FIFOLIFO_PEEK_EN
        , input peek_data
`endif
    );

    modport slave (
        input  mode_sel, Wren, Rden, data_in, err_clr,
        output DataOut, data_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow, mode_q
`ifdef FIFOLIFO_PEEK_EN
        , output peek_data
`endif
    );

endinterface

// File: rtl/fifo_lifo_ram.sv
// Storage array: one synchronous write port, one asynchronous read port.
// The read is combinational so the caller can register it and so a
// same-cycle write to the read address still returns the old word.
module fifo_lifo_ram
    import fifo_lifo_pkg::*;
#(
    parameter int DAT_WIDTH = 32,
    parameter int DEPTH     = 64,
    localparam int PTR_W    = bits_for(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [PTR_W-1:0]     waddr,
    input  logic [DAT_WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0]     raddr,
    output logic [DAT_WIDTH-1:0] rdata
);
    logic [DAT_WIDTH-1:0] mem [DEPTH];

    // Write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_lifo_buffer.sv
// Run-time selectable FIFO/LIFO buffer with occupancy flags and sticky errors.
// Optional feature macro: FIFOLIFO_PEEK_EN exposes the next pop word.
module fifo_lifo_buffer
    import fifo_lifo_pkg::*;
#(
    parameter int DAT_WIDTH = 32,
    parameter int DEPTH     = 64,
    parameter int AF_LEVEL  = DEPTH - 4,
    parameter int AE_LEVEL  = 4,
    localparam int CNT_W    = bits_for(DEPTH + 1),
    localparam int PTR_W    = bits_for(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    fifo_lifo_buffer_if.slave bus
);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     cnt_q;
    logic [DAT_WIDTH-1:0] dout_q;
    logic                 dv_q;
    logic                 ovf_q;
    logic                 unf_q;
    logic                 mode_r;

    logic                 full;
    logic                 empty;
    logic                 push_acc;
    logic                 pop_acc;
    logic [PTR_W-1:0]     top_m1;
    logic [PTR_W-1:0]     waddr;
    logic [PTR_W-1:0]     raddr;
    logic [DAT_WIDTH-1:0] rd_data;

    assign full     = (cnt_q == DEPTH_C);
    assign empty    = (cnt_q == '0);
    assign push_acc = bus.Wren & (~full | bus.Rden);
    assign pop_acc  = bus.Rden & ~empty;

    // Low bits of count wrap DEPTH to 0, so subtracting one still lands on
    // the top entry when the stack is full.
    assign top_m1 = cnt_q[PTR_W-1:0] - PTR_W'(1);

    // Address selection: FIFO uses its pointers, LIFO addresses from count
    // and overwrites the top entry on a simultaneous push+pop.
    always_comb begin
        waddr = wr_ptr;
        raddr = rd_ptr;
        if (mode_r == MODE_LIFO) begin
            raddr = top_m1;
            waddr = pop_acc ? top_m1 : cnt_q[PTR_W-1:0];
        end
    end

    fifo_lifo_ram #(
        .DAT_WIDTH (DAT_WIDTH),
        .DEPTH     (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push_acc & ~rst),
        .waddr (waddr),
        .wdata (bus.data_in),
        .raddr (raddr),
        .rdata (rd_data)
    );

    // Pointers, occupancy, registered pop data, sticky errors and mode latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            dv_q   <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            mode_r <= bus.mode_sel;
        end else begin
            dv_q <= pop_acc;
            if (pop_acc) begin
                dout_q <= rd_data;
            end

            if (mode_r == MODE_FIFO) begin
                if (push_acc) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop_acc)  rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case ({push_acc, pop_acc})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase

            if (bus.Wren & ~push_acc) begin
                ovf_q <= 1'b1;
            end else if (bus.err_clr) begin
                ovf_q <= 1'b0;
            end

            if (bus.Rden & ~pop_acc) begin
                unf_q <= 1'b1;
            end else if (bus.err_clr) begin
                unf_q <= 1'b0;
            end

            // Discipline may only change while nothing is stored.
            if (empty & ~push_acc) begin
                mode_r <= bus.mode_sel;
            end
        end
    end

    assign bus.DataOut      = dout_q;
    assign bus.data_valid   = dv_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (cnt_q >= AF_C);
    assign bus.almost_empty = (cnt_q <= AE_C);
    assign bus.count        = cnt_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
    assign bus.mode_q       = mode_r;

`ifdef FIFOLIFO_PEEK_EN
    assign bus.peek_data = empty ? '0 : rd_data;
`endif

endmodule
